// File: rtl/id_exe.sv
// id_exe: pipeline register between decode and execute.
// Each edge it holds (execute stalled), inserts a NOP bubble (flush or
// load-use stall in decode) or captures the decoded instruction. It also
// reports load-hazard information back to decode and keeps a saturating
// count of inserted bubbles.
module id_exe #(
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    parameter logic [6:0]  LOAD_OPCODE = 7'b0000011
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic        stall_id_i,
    input  logic        stall_exe_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic        csr_we_o,
    output logic [11:0] csr_addr_o,
    output logic        valid_o,
    output logic [4:0]  exe_rd_o,
    output logic        pre_inst_is_load_o,
    output logic [31:0] bubble_cnt_o
);

    // Pipeline register contents
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_reg_we;
    logic [4:0]  r_reg_waddr;
    logic        r_csr_we;
    logic [11:0] r_csr_addr;
    logic        r_valid;
    logic [31:0] r_bubble_cnt;

    // Per-edge action decode. Execute stall wins over everything so the
    // instruction sitting in execute is never lost, even if a flush arrives.
    logic w_hold;
    logic w_bubble;
    logic w_cnt_sat;

    assign w_hold    = stall_exe_i;
    assign w_bubble  = !stall_exe_i && (flush_i || stall_id_i);
    assign w_cnt_sat = (r_bubble_cnt == 32'hFFFF_FFFF);

    // Register update: reset / hold / bubble / capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inst       <= NOP_INST;
            r_inst_addr  <= 32'd0;
            r_op1        <= 32'd0;
            r_op2        <= 32'd0;
            r_reg_we     <= 1'b0;
            r_reg_waddr  <= 5'd0;
            r_csr_we     <= 1'b0;
            r_csr_addr   <= 12'd0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= 32'd0;
        end else if (w_hold) begin
            r_inst       <= r_inst;
            r_inst_addr  <= r_inst_addr;
            r_op1        <= r_op1;
            r_op2        <= r_op2;
            r_reg_we     <= r_reg_we;
            r_reg_waddr  <= r_reg_waddr;
            r_csr_we     <= r_csr_we;
            r_csr_addr   <= r_csr_addr;
            r_valid      <= r_valid;
            r_bubble_cnt <= r_bubble_cnt;
        end else if (w_bubble) begin
            r_inst       <= NOP_INST;
            r_inst_addr  <= 32'd0;
            r_op1        <= 32'd0;
            r_op2        <= 32'd0;
            r_reg_we     <= 1'b0;
            r_reg_waddr  <= 5'd0;
            r_csr_we     <= 1'b0;
            r_csr_addr   <= 12'd0;
            r_valid      <= 1'b0;
            // Saturate rather than wrap so the monitor never under-reports
            r_bubble_cnt <= w_cnt_sat ? r_bubble_cnt : r_bubble_cnt + 32'd1;
        end else begin
            r_inst       <= inst_i;
            r_inst_addr  <= inst_addr_i;
            r_op1        <= op1_i;
            r_op2        <= op2_i;
            r_reg_we     <= reg_we_i;
            r_reg_waddr  <= reg_waddr_i;
            r_csr_we     <= csr_we_i;
            r_csr_addr   <= csr_addr_i;
            r_valid      <= 1'b1;
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign inst_o      = r_inst;
    assign inst_addr_o = r_inst_addr;
    assign op1_o       = r_op1;
    assign op2_o       = r_op2;
    assign reg_we_o    = r_reg_we;
    assign reg_waddr_o = r_reg_waddr;
    assign csr_we_o    = r_csr_we;
    assign csr_addr_o  = r_csr_addr;
    assign valid_o     = r_valid;
    assign bubble_cnt_o = r_bubble_cnt;

    // Hazard feedback to decode, derived from registered state only.
    // A load writing x0 produces nothing to wait for.
    assign exe_rd_o           = r_reg_waddr;
    assign pre_inst_is_load_o = r_valid && r_reg_we &&
                                (r_inst[6:0] == LOAD_OPCODE) &&
                                (r_reg_waddr != 5'd0);

endmodule

// File: tb/tb_id_exe.sv
// Directed bench for id_exe: reset, capture, load-use bubble, execute
// stall with flush, flush, and bubble counter saturation.
module tb_id_exe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
    logic        reg_we_i, csr_we_i;
    logic [4:0]  reg_waddr_i;
    logic [11:0] csr_addr_i;
    logic        stall_id_i, stall_exe_i, flush_i;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, bubble_cnt_o;
    logic        reg_we_o, csr_we_o, valid_o, pre_inst_is_load_o;
    logic [4:0]  reg_waddr_o, exe_rd_o;
    logic [11:0] csr_addr_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt = 32'd0;

    id_exe dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .inst_i             (inst_i),
        .inst_addr_i        (inst_addr_i),
        .op1_i              (op1_i),
        .op2_i              (op2_i),
        .reg_we_i           (reg_we_i),
        .reg_waddr_i        (reg_waddr_i),
        .csr_we_i           (csr_we_i),
        .csr_addr_i         (csr_addr_i),
        .stall_id_i         (stall_id_i),
        .stall_exe_i        (stall_exe_i),
        .flush_i            (flush_i),
        .inst_o             (inst_o),
        .inst_addr_o        (inst_addr_o),
        .op1_o              (op1_o),
        .op2_o              (op2_o),
        .reg_we_o           (reg_we_o),
        .reg_waddr_o        (reg_waddr_o),
        .csr_we_o           (csr_we_o),
        .csr_addr_o         (csr_addr_o),
        .valid_o            (valid_o),
        .exe_rd_o           (exe_rd_o),
        .pre_inst_is_load_o (pre_inst_is_load_o),
        .bubble_cnt_o       (bubble_cnt_o)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: set decode-side inputs
    task automatic drive(input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [4:0] wa,
                         input logic cwe, input logic [11:0] ca);
        inst_i      = inst;
        inst_addr_i = addr;
        op1_i       = a;
        op2_i       = b;
        reg_we_i    = we;
        reg_waddr_i = wa;
        csr_we_i    = cwe;
        csr_addr_i  = ca;
    endtask

    // Driver: set control inputs
    task automatic ctrl(input logic sid, input logic sex, input logic fl);
        stall_id_i  = sid;
        stall_exe_i = sex;
        flush_i     = fl;
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 12'h0);
        ctrl(1'b0, 1'b0, 1'b0);
        #12;
        checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (bubble_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", bubble_cnt_o); end
        rst = 1'b0;
        // one bubble so the count is non-zero before the mid-cycle reset
        ctrl(1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bubble_cnt_o !== 32'd1) begin errors++; $display("FAIL pre_reset_cnt got=%h exp=1", bubble_cnt_o); end
        // capture addi x5,x0,7
        ctrl(1'b0, 1'b0, 1'b0);
        drive(32'h0070_0293, 32'h0000_0100, 32'd0, 32'd7, 1'b1, 5'd5, 1'b0, 12'h0);
        step();
        checks++; if (inst_o !== 32'h0070_0293 || valid_o !== 1'b1) begin errors++; $display("FAIL addi_capture got=%h/%b exp=00700293/1", inst_o, valid_o); end
        // asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        checks++; if (inst_o !== NOP) begin errors++; $display("FAIL async_reset_inst got=%h exp=%h", inst_o, NOP); end
        checks++; if (valid_o !== 1'b0 || reg_we_o !== 1'b0 || reg_waddr_o !== 5'd0) begin errors++; $display("FAIL async_reset_ctl got=%b/%b/%0d exp=0/0/0", valid_o, reg_we_o, reg_waddr_o); end
        checks++; if (bubble_cnt_o !== 32'd0) begin errors++; $display("FAIL async_reset_cnt got=%h exp=0", bubble_cnt_o); end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_capture();
        ctrl(1'b0, 1'b0, 1'b0);
        drive(32'h0020_81B3, 32'h0000_0200, 32'd5, 32'd9, 1'b1, 5'd3, 1'b0, 12'h0);
        step();
        checks++; if (op1_o !== 32'd5 || op2_o !== 32'd9) begin errors++; $display("FAIL cap_ops got=%0d/%0d exp=5/9", op1_o, op2_o); end
        checks++; if (reg_waddr_o !== 5'd3 || exe_rd_o !== 5'd3) begin errors++; $display("FAIL cap_rd got=%0d/%0d exp=3/3", reg_waddr_o, exe_rd_o); end
        checks++; if (valid_o !== 1'b1 || pre_inst_is_load_o !== 1'b0) begin errors++; $display("FAIL cap_flags got=%b/%b exp=1/0", valid_o, pre_inst_is_load_o); end
        checks++; if (inst_addr_o !== 32'h0000_0200 || inst_o !== 32'h0020_81B3) begin errors++; $display("FAIL cap_inst got=%h/%h exp=00000200/002081b3", inst_addr_o, inst_o); end
        checks++; if (bubble_cnt_o !== exp_cnt) begin errors++; $display("FAIL cap_cnt got=%h exp=%h", bubble_cnt_o, exp_cnt); end
    endtask

    task automatic test_load_use();
        // lw x0 is not a hazard
        ctrl(1'b0, 1'b0, 1'b0);
        drive(32'h0000_A003, 32'h0000_0204, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 12'h0);
        step();
        checks++; if (pre_inst_is_load_o !== 1'b0) begin errors++; $display("FAIL load_x0 got=%b exp=0", pre_inst_is_load_o); end
        // lw x6,0(x1)
        drive(32'h0000_A303, 32'h0000_0208, 32'd64, 32'd0, 1'b1, 5'd6, 1'b0, 12'h0);
        step();
        checks++; if (pre_inst_is_load_o !== 1'b1 || exe_rd_o !== 5'd6) begin errors++; $display("FAIL load_flag got=%b/%0d exp=1/6", pre_inst_is_load_o, exe_rd_o); end
        // decode stalls one cycle on the dependent add x7,x6,x1
        drive(32'h0013_03B3, 32'h0000_020C, 32'd1, 32'd2, 1'b1, 5'd7, 1'b0, 12'h0);
        ctrl(1'b1, 1'b0, 1'b0);
        step();
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (inst_o !== NOP || valid_o !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%h/%b exp=%h/0", inst_o, valid_o, NOP); end
        checks++; if (bubble_cnt_o !== exp_cnt) begin errors++; $display("FAIL lu_cnt got=%h exp=%h", bubble_cnt_o, exp_cnt); end
        checks++; if (pre_inst_is_load_o !== 1'b0 || reg_we_o !== 1'b0 || op1_o !== 32'd0) begin errors++; $display("FAIL lu_clear got=%b/%b/%h exp=0/0/0", pre_inst_is_load_o, reg_we_o, op1_o); end
        // dependent instruction captured with forwarded operand
        ctrl(1'b0, 1'b0, 1'b0);
        drive(32'h0013_03B3, 32'h0000_020C, 32'd77, 32'd2, 1'b1, 5'd7, 1'b0, 12'h0);
        step();
        checks++; if (inst_o !== 32'h0013_03B3 || valid_o !== 1'b1 || op1_o !== 32'd77) begin errors++; $display("FAIL lu_dep got=%h/%b/%0d exp=001303b3/1/77", inst_o, valid_o, op1_o); end
    endtask

    task automatic test_exe_stall();
        ctrl(1'b0, 1'b0, 1'b0);
        drive(32'h0000_A303, 32'h0000_0300, 32'd16, 32'd0, 1'b1, 5'd6, 1'b0, 12'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            // stall_id also raised on the middle cycle: both stalls still hold
            ctrl(i == 1, 1'b1, 1'b1);
            drive(32'h1111_0000 + i, 32'h400 + i, i, i + 1, 1'b0, 5'd9, 1'b1, 12'h305);
            step();
            checks++; if (inst_o !== 32'h0000_A303 || inst_addr_o !== 32'h0000_0300 || op1_o !== 32'd16) begin errors++; $display("FAIL hold_data%0d got=%h/%h/%0d exp=0000a303/00000300/16", i, inst_o, inst_addr_o, op1_o); end
            checks++; if (pre_inst_is_load_o !== 1'b1 || valid_o !== 1'b1 || csr_we_o !== 1'b0) begin errors++; $display("FAIL hold_flags%0d got=%b/%b/%b exp=1/1/0", i, pre_inst_is_load_o, valid_o, csr_we_o); end
            checks++; if (bubble_cnt_o !== exp_cnt) begin errors++; $display("FAIL hold_cnt%0d got=%h exp=%h", i, bubble_cnt_o, exp_cnt); end
        end
        ctrl(1'b0, 1'b0, 1'b0);
        drive(32'h0020_81B3, 32'h0000_0304, 32'd3, 32'd4, 1'b1, 5'd3, 1'b0, 12'h0);
        step();
        checks++; if (inst_o !== 32'h0020_81B3 || op2_o !== 32'd4 || exe_rd_o !== 5'd3) begin errors++; $display("FAIL hold_resume got=%h/%0d/%0d exp=002081b3/4/3", inst_o, op2_o, exe_rd_o); end
    endtask

    task automatic test_flush();
        ctrl(1'b0, 1'b0, 1'b1);
        drive(32'h3000_1073, 32'h0000_0500, 32'd8, 32'd9, 1'b1, 5'd10, 1'b1, 12'h300);
        step();
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (reg_we_o !== 1'b0 || csr_we_o !== 1'b0) begin errors++; $display("FAIL flush_we got=%b/%b exp=0/0", reg_we_o, csr_we_o); end
        checks++; if (inst_o !== NOP || csr_addr_o !== 12'h0 || inst_addr_o !== 32'd0) begin errors++; $display("FAIL flush_inst got=%h/%h/%h exp=%h/000/0", inst_o, csr_addr_o, inst_addr_o, NOP); end
        checks++; if (bubble_cnt_o !== exp_cnt) begin errors++; $display("FAIL flush_cnt got=%h exp=%h", bubble_cnt_o, exp_cnt); end
        // back-to-back capture straight after a flush, CSR fields included
        ctrl(1'b0, 1'b0, 1'b0);
        step();
        checks++; if (csr_we_o !== 1'b1 || csr_addr_o !== 12'h300 || valid_o !== 1'b1) begin errors++; $display("FAIL post_flush got=%b/%h/%b exp=1/300/1", csr_we_o, csr_addr_o, valid_o); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.r_bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_bubble_cnt;
        #1;
        checks++; if (bubble_cnt_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffffffe", bubble_cnt_o); end
        ctrl(1'b0, 1'b0, 1'b1);
        step();
        checks++; if (bubble_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first got=%h exp=ffffffff", bubble_cnt_o); end
        step();
        checks++; if (bubble_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_second got=%h exp=ffffffff", bubble_cnt_o); end
        step();
        checks++; if (bubble_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_third got=%h exp=ffffffff", bubble_cnt_o); end
        // capture must not disturb the saturated count
        ctrl(1'b0, 1'b0, 1'b0);
        step();
        checks++; if (bubble_cnt_o !== 32'hFFFF_FFFF || valid_o !== 1'b1) begin errors++; $display("FAIL sat_capture got=%h/%b exp=ffffffff/1", bubble_cnt_o, valid_o); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_exe_stall();
        test_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_exe.md
# id_exe

Pipeline register between the decode stage (`id`) and the execute stage (`exe`) of the 5-stage RV32 core. It captures decoded operands and control each cycle, holds them when execute stalls, and inserts a NOP bubble on a load-use hazard or a control-flow flush. It also returns load-hazard information (`exe_rd_o`, `pre_inst_is_load_o`) to `id`, and keeps a saturating count of inserted bubbles for performance monitoring.

## Interface

Parameters:
- `NOP_INST`, default `` `NOP `` (32'h0000_0013): instruction word driven into a bubble.
- `LOAD_OPCODE`, default 7'b0000011: opcode used to flag loads.

Ports:
- `clk_i`  input  1  core clock; all state changes on the rising edge.
- `rst_i`  input  1  asynchronous, active-high reset.
- `inst_i`  input  `` `DATA_WIDTH `` (32)  decoded instruction from `id`.
- `inst_addr_i`  input  `` `ADDR_WIDTH `` (32)  PC of `inst_i`.
- `op1_i`, `op2_i`  input  `` `RDATA_WIDTH `` (32)  forwarded operands from `id`.
- `reg_we_i`  input  1  register write enable.
- `reg_waddr_i`  input  `` `RADDR_WIDTH `` (5)  destination register.
- `csr_we_i`  input  1  CSR write enable.
- `csr_addr_i`  input  `` `CSR_ADDR_WIDTH `` (12)  CSR address.
- `stall_id_i`  input  1  from `ctrl`: the decode stage is frozen.
- `stall_exe_i`  input  1  from `ctrl`: the execute stage is frozen.
- `flush_i`  input  1  from `ctrl`/`exe`: a taken branch or jump kills the instruction in decode.
- `inst_o`, `inst_addr_o`, `op1_o`, `op2_o`, `reg_we_o`, `reg_waddr_o`, `csr_we_o`, `csr_addr_o`  output  same widths as the matching inputs  registered copies delivered to `exe`.
- `valid_o`  output  1  the register holds a real instruction, not a bubble.
- `exe_rd_o`  output  5  equals `reg_waddr_o`; goes to `id` `exe_rd_i`.
- `pre_inst_is_load_o`  output  1  to `id` for load-hazard detection.
- `bubble_cnt_o`  output  32  saturating count of inserted bubbles.

## Operation

Each rising edge performs exactly one action, chosen in this priority order:
1. `stall_exe_i` = 1 → HOLD. All registers keep their value. This holds even if `flush_i` = 1; `ctrl` must not flush while execute is stalled, and the register must not lose the execute instruction.
2. `flush_i` = 1 → BUBBLE.
3. `stall_id_i` = 1 → BUBBLE. This is the load-use case: decode waits while execute advances.
4. Otherwise → CAPTURE. All `*_o` take the matching `*_i`, and `valid_o` = 1.

BUBBLE loads the register with:
- `inst_o` = `NOP_INST`
- `inst_addr_o`, `op1_o`, `op2_o` = 0
- `reg_we_o`, `csr_we_o` = 0
- `reg_waddr_o` = 0, `csr_addr_o` = 0
- `valid_o` = 0

Derived outputs (combinational from registers only):
- `pre_inst_is_load_o` = `valid_o` & `reg_we_o` & (`inst_o[6:0]` == `LOAD_OPCODE`) & (`reg_waddr_o` != 0).
- `exe_rd_o` = `reg_waddr_o`.

Bubble counter:
- `bubble_cnt_o` increments by 1 on every BUBBLE edge.
- It saturates at 32'hFFFF_FFFF and never wraps.
- It is unchanged on HOLD and CAPTURE.

## Timing

- Latency: one cycle from `id` inputs to `*_o`.
- No combinational path from any input to any output.
- Reset: asserting `rst_i` immediately (asynchronously, mid-cycle included) forces:
  - the BUBBLE values on all `*_o`
  - `valid_o` = 0, `pre_inst_is_load_o` = 0
  - `bubble_cnt_o` = 0
- Reset assertion does not count as a bubble.
- On the first edge after `rst_i` deasserts, normal priority applies.
- A load-use stall is a single cycle: a load is captured at edge N, `id` raises `stall_id_i` during cycle N, a bubble is inserted at edge N+1, and the dependent instruction is captured at edge N+2 with its operand forwarded by `id` from mem.
- `stall_id_i` and `stall_exe_i` together → HOLD.
- A held load keeps `pre_inst_is_load_o` = 1 for every held cycle.

## Test plan

1. Reset mid-stream: drive CAPTURE of `addi x5,x0,7` (0x00700293), then pulse `rst_i` asynchronously mid-cycle → outputs immediately show `inst_o` = 0x00000013, `valid_o` = 0, `bubble_cnt_o` = 0.
2. Plain capture: `inst_i` = 0x002081B3 (add x3,x1,x2), `op1_i` = 5, `op2_i` = 9, `reg_we_i` = 1, `reg_waddr_i` = 3 → next edge: `op1_o` = 5, `op2_o` = 9, `reg_waddr_o` = 3, `valid_o` = 1, `pre_inst_is_load_o` = 0.
3. Load-use: capture `lw x6,0(x1)` (0x0000A303) → `pre_inst_is_load_o` = 1 and `exe_rd_o` = 6. Then `stall_id_i` = 1 for one cycle → next edge `inst_o` = NOP, `valid_o` = 0, `bubble_cnt_o` = 1. The following edge captures the dependent instruction.
4. Execute stall with flush: hold `stall_exe_i` = 1 for 3 cycles with `flush_i` = 1 and changing inputs → outputs frozen, `bubble_cnt_o` unchanged. Deassert both → capture resumes.
5. Flush: `flush_i` = 1 with valid `inst_i` and `csr_we_i` = 1 → `reg_we_o` = 0, `csr_we_o` = 0, `inst_o` = NOP, count +1.
6. Counter saturation: force `bubble_cnt_o` to 32'hFFFF_FFFE via hierarchical deposit, then apply 3 flushes → reads 32'hFFFF_FFFF and stays there.
